// File: rtl/sqrt_host_ctrl.sv
// Host-side controller for the FP16 sqrt unit's shared IO_DATA/ENABLE/RESULT bus.
// Optional WAIT watchdog abort is compiled in when SQRT_HOST_TIMEOUT_EN is defined.
module sqrt_host_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [15:0] REQ_DATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic        RSP_NAN,
  output logic        RSP_PINF,
  output logic        RSP_NINF,
  output logic        RSP_TIMEOUT,
  inout  wire  [15:0] IO_DATA,
  output logic        ENABLE,
  input  logic        RESULT,
  input  logic        IS_NAN,
  input  logic        IS_PINF,
  input  logic        IS_NINF
);

`ifdef SQRT_HOST_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_GAP, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [15:0] op_q, op_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        enable_q, enable_d;
  logic        io_oe_q, io_oe_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_nan_q, rsp_nan_d;
  logic        rsp_pinf_q, rsp_pinf_d;
  logic        rsp_ninf_q, rsp_ninf_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    state_d       = state_q;
    op_d          = op_q;
    wait_cnt_d    = wait_cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_nan_d     = rsp_nan_q;
    rsp_pinf_d    = rsp_pinf_q;
    rsp_ninf_d    = rsp_ninf_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          op_d    = REQ_DATA;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: state_d = S_GAP;
      S_GAP: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
        if (RESULT) begin
          rsp_data_d    = IO_DATA;
          rsp_nan_d     = IS_NAN;
          rsp_pinf_d    = IS_PINF;
          rsp_ninf_d    = IS_NINF;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (TIMEOUT_EN && (wait_cnt_q >= TIMEOUT_LAST)) begin
          // Abort reports a canonical quiet NaN so consumers need no special case.
          rsp_data_d    = 16'hFE00;
          rsp_nan_d     = 1'b1;
          rsp_pinf_d    = 1'b0;
          rsp_ninf_d    = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin-level controls are decoded from the next state and registered, keeping them glitch-free.
    enable_d    = (state_d == S_DRIVE) || (state_d == S_GAP) || (state_d == S_WAIT);
    io_oe_d     = (state_d == S_DRIVE);
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: op_q is reset along with the control state so the bus never carries X after reset.
    if (!RESET_N) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      wait_cnt_q    <= '0;
      enable_q      <= 1'b0;
      io_oe_q       <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_nan_q     <= 1'b0;
      rsp_pinf_q    <= 1'b0;
      rsp_ninf_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from pre-edge values.
      state_q       <= state_d;
      op_q          <= op_d;
      wait_cnt_q    <= wait_cnt_d;
      enable_q      <= enable_d;
      io_oe_q       <= io_oe_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_nan_q     <= rsp_nan_d;
      rsp_pinf_q    <= rsp_pinf_d;
      rsp_ninf_q    <= rsp_ninf_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign IO_DATA     = io_oe_q ? op_q : 16'hzzzz;
  assign ENABLE      = enable_q;
  assign REQ_READY   = req_ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_NAN     = rsp_nan_q;
  assign RSP_PINF    = rsp_pinf_q;
  assign RSP_NINF    = rsp_ninf_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

endmodule
